// File: rtl/sata_phy_pkg.sv
// Shared types for the SATA PHY reset sequencer: FSM states, service phases
// and GTX line-rate codes.
package sata_phy_pkg;

  typedef enum logic [2:0] {
    LOCK,
    HOLD,
    WAIT,
    READY,
    TXPCS,
    RXRST,
    RATE
  } state_t;

  // Sub-phase of a serviced request: reset pulse, wait for GTX done, ack handshake.
  typedef enum logic [1:0] {
    PH_PULSE,
    PH_DONE,
    PH_ACK
  } phase_t;

  localparam logic [2:0] RATE_GEN1 = 3'd2;
  localparam logic [2:0] RATE_GEN2 = 3'd1;
  localparam logic [2:0] RATE_GEN3 = 3'd0;

endpackage

// File: rtl/sata_pulse_timer.sv
// Loadable down-counter: load N-1 to get a done flag on the N-th cycle after load.
module sata_pulse_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sata_phy_rst_seq.sv
// SATA PHY reset/recalibration/rate-change sequencer between oob_ctrl and gtx_wrap.
// Optional SATA_PHY_RST_SEQ_DEBUG_EN adds debug_cnt (timeout retries, lock losses).
module sata_phy_rst_seq
  import sata_phy_pkg::*;
#(
  parameter int                   RST_HOLD_LEN = 8,
  parameter int                   PULSE_LEN    = 8,
  parameter int                   TIMEOUT_W    = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT      = 16'hffff,
  parameter int                   RATE_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cplllock,
  input  logic              usrpll_locked,
  input  logic              txresetdone,
  input  logic              rxresetdone,
  output logic              sata_rst,
  output logic              txuserrdy,
  output logic              rxuserrdy,
  output logic              gtx_ready,
  output logic              gtx_configured,
  input  logic              txpcsreset_req,
  output logic              txpcsreset,
  output logic              recal_tx_done,
  input  logic              rxreset_req,
  output logic              rxreset,
  output logic              rxreset_ack,
  input  logic              rate_req,
  input  logic [RATE_W-1:0] rate_sel,
  output logic [RATE_W-1:0] txrate,
  output logic [RATE_W-1:0] rxrate,
  input  logic              txratedone,
  input  logic              rxratedone,
  output logic              rate_ack
`ifdef SATA_PHY_RST_SEQ_DEBUG_EN
  ,
  output logic [15:0]       debug_cnt
`endif
);

  localparam logic [7:0]           HOLD_VAL  = 8'(RST_HOLD_LEN - 1);
  localparam logic [7:0]           PULSE_VAL = 8'(PULSE_LEN - 1);
  localparam logic [TIMEOUT_W-1:0] TO_VAL    = TIMEOUT - 1'b1;

  state_t            r_state, w_state_nx;
  phase_t            r_phase, w_phase_nx;
  logic              w_lock, w_in_rst, w_same, w_both;
  logic              w_hold_ld, w_hold_done, w_to_ld, w_to_done;
  logic              w_rate_ld, w_timeout_evt;
  logic [7:0]        w_hold_val;
  logic              r_gtx_ready, r_cfg, r_txrd, r_rxrd;
  logic [RATE_W-1:0] r_rate;

  assign w_lock = cplllock & usrpll_locked;
  assign w_same = (rate_sel == r_rate);
  assign w_both = (r_txrd | txratedone) & (r_rxrd | rxratedone);

  sata_pulse_timer #(.CNT_W(8)) u_hold_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_hold_ld),
    .i_load_val (w_hold_val),
    .o_done     (w_hold_done)
  );

  sata_pulse_timer #(.CNT_W(TIMEOUT_W)) u_to_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_to_ld),
    .i_load_val (TO_VAL),
    .o_done     (w_to_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOCK;
      r_phase <= PH_PULSE;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_phase_nx    = r_phase;
    w_hold_ld     = 1'b0;
    w_hold_val    = HOLD_VAL;
    w_to_ld       = 1'b0;
    w_rate_ld     = 1'b0;
    w_timeout_evt = 1'b0;
    // Lock loss overrides everything, including a pending timeout.
    if (r_state != LOCK && !w_lock) begin
      w_state_nx = LOCK;
    end else begin
      case (r_state)
        LOCK: if (w_lock) begin
          w_state_nx = HOLD;
          w_hold_ld  = 1'b1;
        end
        HOLD: if (w_hold_done) begin
          w_state_nx = WAIT;
          w_to_ld    = 1'b1;
        end
        WAIT: begin
          if (txresetdone && rxresetdone) w_state_nx = READY;
          else if (w_to_done)             w_timeout_evt = 1'b1;
        end
        READY: begin
          if (rate_req) begin
            w_state_nx = RATE;
            w_phase_nx = PH_DONE;
            w_to_ld    = 1'b1;
            w_rate_ld  = 1'b1;
          end else if (rxreset_req || txpcsreset_req) begin
            w_state_nx = rxreset_req ? RXRST : TXPCS;
            w_phase_nx = PH_PULSE;
            w_hold_ld  = 1'b1;
            w_hold_val = PULSE_VAL;
          end
        end
        TXPCS, RXRST: begin
          case (r_phase)
            PH_PULSE: if (w_hold_done) begin
              w_phase_nx = PH_DONE;
              w_to_ld    = 1'b1;
            end
            PH_DONE: begin
              if ((r_state == TXPCS) ? txresetdone : rxresetdone) w_phase_nx = PH_ACK;
              else if (w_to_done)                                   w_timeout_evt = 1'b1;
            end
            default: if (!((r_state == TXPCS) ? txpcsreset_req : rxreset_req)) w_state_nx = READY;
          endcase
        end
        RATE: begin
          if (r_phase == PH_DONE) begin
            if (w_both)         w_phase_nx = PH_ACK;
            else if (w_to_done) w_timeout_evt = 1'b1;
          end else if (!rate_req) begin
            w_state_nx = READY;
          end
        end
        default: w_state_nx = LOCK;
      endcase
    end
    if (w_timeout_evt) begin
      w_state_nx = HOLD;
      w_hold_ld  = 1'b1;
      w_hold_val = HOLD_VAL;
    end
  end

  // Rate register and sticky ratedone captures; an unchanged rate counts as already done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rate <= '0;
      r_txrd <= 1'b0;
      r_rxrd <= 1'b0;
    end else if (w_rate_ld) begin
      r_rate <= rate_sel;
      r_txrd <= w_same;
      r_rxrd <= w_same;
    end else if (r_state == RATE) begin
      r_txrd <= r_txrd | txratedone;
      r_rxrd <= r_rxrd | rxratedone;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gtx_ready <= 1'b0;
      r_cfg       <= 1'b0;
    end else begin
      r_gtx_ready <= txuserrdy & rxuserrdy & txresetdone & rxresetdone;
      r_cfg       <= r_cfg | (txuserrdy & rxuserrdy & txresetdone & rxresetdone);
    end
  end

  assign w_in_rst       = (r_state == LOCK) || (r_state == HOLD);
  assign sata_rst       = w_in_rst;
  assign txuserrdy      = !w_in_rst;
  assign rxuserrdy      = !w_in_rst && !(r_state == RXRST && r_phase == PH_PULSE);
  assign txpcsreset     = (r_state == TXPCS) && (r_phase == PH_PULSE);
  assign recal_tx_done  = (r_state == TXPCS) && (r_phase == PH_ACK);
  assign rxreset        = (r_state == RXRST) && (r_phase == PH_PULSE);
  assign rxreset_ack    = (r_state == RXRST) && (r_phase == PH_ACK);
  assign rate_ack       = (r_state == RATE) && (r_phase == PH_ACK);
  assign txrate         = r_rate;
  assign rxrate         = r_rate;
  assign gtx_ready      = r_gtx_ready;
  assign gtx_configured = r_cfg;

`ifdef SATA_PHY_RST_SEQ_DEBUG_EN
  logic [7:0] r_dbg_retry, r_dbg_loss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbg_retry <= '0;
      r_dbg_loss  <= '0;
    end else begin
      if (w_timeout_evt && r_dbg_retry != 8'hff)                    r_dbg_retry <= r_dbg_retry + 1'b1;
      if (r_state != LOCK && !w_lock && r_dbg_loss != 8'hff)       r_dbg_loss  <= r_dbg_loss + 1'b1;
    end
  end

  assign debug_cnt = {r_dbg_loss, r_dbg_retry};
`endif

endmodule

// File: tb/tb_sata_phy_rst_seq.sv
// Directed bring-up / request / rate / timeout / lock-loss sequence with randomized timing.
module tb_sata_phy_rst_seq;
  import sata_phy_pkg::*;

  localparam int HOLD  = 8;
  localparam int PULSE = 8;
  localparam int TO    = 50;
  localparam int RW    = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cplllock = 1'b0, usrpll_locked = 1'b0;
  logic          txresetdone = 1'b0, rxresetdone = 1'b0;
  logic          txpcsreset_req = 1'b0, rxreset_req = 1'b0, rate_req = 1'b0;
  logic          txratedone = 1'b0, rxratedone = 1'b0;
  logic [RW-1:0] rate_sel = '0;
  logic          sata_rst, txuserrdy, rxuserrdy, gtx_ready, gtx_configured;
  logic          txpcsreset, recal_tx_done, rxreset, rxreset_ack, rate_ack;
  logic [RW-1:0] txrate, rxrate;
`ifdef SATA_PHY_RST_SEQ_DEBUG_EN
  logic [15:0]   debug_cnt;
`endif

  int            n_pass = 0, n_total = 0;
  logic [RW-1:0] m_rate = '0;
  int            m_retry = 0, m_loss = 0;

  always #5 clk = ~clk;

  sata_phy_rst_seq #(
    .RST_HOLD_LEN (HOLD),
    .PULSE_LEN    (PULSE),
    .TIMEOUT_W    (16),
    .TIMEOUT      (16'(TO)),
    .RATE_W       (RW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cplllock       (cplllock),
    .usrpll_locked  (usrpll_locked),
    .txresetdone    (txresetdone),
    .rxresetdone    (rxresetdone),
    .sata_rst       (sata_rst),
    .txuserrdy      (txuserrdy),
    .rxuserrdy      (rxuserrdy),
    .gtx_ready      (gtx_ready),
    .gtx_configured (gtx_configured),
    .txpcsreset_req (txpcsreset_req),
    .txpcsreset     (txpcsreset),
    .recal_tx_done  (recal_tx_done),
    .rxreset_req    (rxreset_req),
    .rxreset        (rxreset),
    .rxreset_ack    (rxreset_ack),
    .rate_req       (rate_req),
    .rate_sel       (rate_sel),
    .txrate         (txrate),
    .rxrate         (rxrate),
    .txratedone     (txratedone),
    .rxratedone     (rxratedone),
    .rate_ack       (rate_ack)
`ifdef SATA_PHY_RST_SEQ_DEBUG_EN
    ,
    .debug_cnt      (debug_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return sata_rst;
      1:       return txpcsreset;
      2:       return rxreset;
      default: return 1'b0;
    endcase
  endfunction

  // Counts consecutive cycles (from the current one) in which signal s equals lvl.
  task automatic run_len(input int s, input logic lvl, output int n);
    n = 0;
    while (sig(s) === lvl && n < 300) begin
      n++;
      step();
    end
  endtask

  task automatic dbg_chk(input string tag);
`ifdef SATA_PHY_RST_SEQ_DEBUG_EN
    chk(tag, debug_cnt, {8'(m_loss), 8'(m_retry)});
`else
    chk(tag, gtx_configured, 1'b1);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d, x, a, b, k, exp_ack;
    logic [RW-1:0] sel;

    // Reset state
    repeat (3) step();
    chk("rst_sata_rst", sata_rst, 1'b1);
    chk("rst_userrdy", {txuserrdy, rxuserrdy}, 2'b00);
    chk("rst_ready", {gtx_ready, gtx_configured}, 2'b00);
    chk("rst_pulses_acks", {txpcsreset, rxreset, recal_tx_done, rxreset_ack, rate_ack}, 5'b0);
    chk("rst_rate", {txrate, rxrate}, '0);
    rst = 1'b0;

    // Lock bring-up: CPLL at cycle 10, user PLL a random 0..3 cycles later
    repeat (10) step();
    chk("lock_wait", sata_rst, 1'b1);
    cplllock = 1'b1;
    d = $urandom_range(0, 3);
    repeat (d) step();
    chk("lock_partial", {sata_rst, txuserrdy}, 2'b10);
    usrpll_locked = 1'b1;
    step();
    run_len(0, 1'b1, n);
    chk("hold_len", n, HOLD);
    chk("wait_userrdy", {txuserrdy, rxuserrdy}, 2'b11);
    repeat (12) step();
    txresetdone = 1'b1;
    repeat (8) step();
    chk("ready_tx_only", gtx_ready, 1'b0);
    rxresetdone = 1'b1;
    chk("ready_same_cycle", gtx_ready, 1'b0);
    step();
    chk("ready_rise", {gtx_ready, gtx_configured}, 2'b11);

    // TX PCS reset with a random txresetdone return delay
    step();
    txpcsreset_req = 1'b1;
    txresetdone    = 1'b0;
    step();
    run_len(1, 1'b1, n);
    chk("txpcs_pulse_len", n, PULSE);
    chk("txpcs_ready_low", {gtx_ready, recal_tx_done}, 2'b00);
    x = $urandom_range(1, 20);
    repeat (x) step();
    chk("txpcs_no_early_ack", recal_tx_done, 1'b0);
    txresetdone = 1'b1;
    step();
    chk("txpcs_ack", recal_tx_done, 1'b1);
    repeat ($urandom_range(1, 5)) step();
    chk("txpcs_ack_hold", recal_tx_done, 1'b1);
    txpcsreset_req = 1'b0;
    step();
    chk("txpcs_ack_drop", {recal_tx_done, txpcsreset}, 2'b00);
    chk("txpcs_ready_back", gtx_ready, 1'b1);

    // Priority: rx and tx requests together; rx serviced first
    rxreset_req    = 1'b1;
    txpcsreset_req = 1'b1;
    rxresetdone    = 1'b0;
    step();
    chk("prio_rx_first", {rxreset, txpcsreset}, 2'b10);
    chk("prio_rxuserrdy", {txuserrdy, rxuserrdy}, 2'b10);
    run_len(2, 1'b1, n);
    chk("rx_pulse_len", n, PULSE);
    chk("rx_userrdy_back", {rxuserrdy, txpcsreset}, 2'b10);
    x = $urandom_range(0, 15);
    repeat (x) begin
      chk("rx_no_early_ack", {rxreset_ack, txpcsreset}, 2'b00);
      step();
    end
    rxresetdone = 1'b1;
    step();
    chk("rx_ack", {rxreset_ack, txpcsreset}, 2'b10);
    repeat ($urandom_range(0, 4)) step();
    rxreset_req = 1'b0;
    step();
    chk("rx_ack_drop", {rxreset_ack, txpcsreset}, 2'b00);
    step();
    chk("prio_tx_after", {txpcsreset, rxreset}, 2'b10);
    run_len(1, 1'b1, n);
    chk("prio_tx_pulse_len", n, PULSE);
    step();
    chk("prio_tx_ack", recal_tx_done, 1'b1);
    txpcsreset_req = 1'b0;
    step();
    chk("prio_tx_ack_drop", recal_tx_done, 1'b0);

    // Rate change to Gen2: txratedone at +5, rxratedone at +9, ack at +10
    rate_sel = RATE_GEN2;
    rate_req = 1'b1;
    step();
    m_rate = RATE_GEN2;
    chk("rate_load", {txrate, rxrate}, {m_rate, m_rate});
    for (int i = 0; i <= 10; i++) begin
      txratedone = (i == 5);
      rxratedone = (i == 9);
      chk("rate_ack_timing", rate_ack, (i >= 10));
      step();
    end
    txratedone = 1'b0;
    rxratedone = 1'b0;
    chk("rate_ack_hold", rate_ack, 1'b1);
    rate_req = 1'b0;
    step();
    chk("rate_ack_drop", rate_ack, 1'b0);

    // Random rate change: ack one cycle after the later done, or at +1 if unchanged
    sel = RW'($urandom_range(0, 2));
    a   = $urandom_range(1, 30);
    b   = $urandom_range(1, 30);
    rate_sel = sel;
    rate_req = 1'b1;
    step();
    exp_ack = (sel == m_rate) ? 1 : ((a > b ? a : b) + 1);
    m_rate  = sel;
    for (int i = 0; i <= 32; i++) begin
      txratedone = (i == a);
      rxratedone = (i == b);
      chk("rate_rand_ack", rate_ack, (i >= exp_ack));
      step();
    end
    txratedone = 1'b0;
    rxratedone = 1'b0;
    chk("rate_rand_value", {txrate, rxrate}, {m_rate, m_rate});
    rate_req = 1'b0;
    step();
    chk("rate_rand_drop", rate_ack, 1'b0);

    // Rate timeout: no ratedone -> full reset after TO cycles, rate kept
    sel      = (m_rate == RATE_GEN1) ? RATE_GEN3 : RATE_GEN1;
    rate_sel = sel;
    rate_req = 1'b1;
    step();
    m_rate = sel;
    run_len(0, 1'b0, n);
    m_retry++;
    chk("rate_to_len", n, TO);
    chk("rate_to_state", {sata_rst, rate_ack, txuserrdy}, 3'b100);
    chk("rate_to_keep", {txrate, rxrate}, {m_rate, m_rate});
    rate_req = 1'b0;
    run_len(0, 1'b1, n);
    chk("rate_to_hold_len", n, HOLD);
    chk("rate_to_ready_low", gtx_ready, 1'b0);
    step();
    chk("rate_to_ready", gtx_ready, 1'b1);
    dbg_chk("dbg_after_rate_to");

    // Lock loss in the middle of a TX PCS pulse
    txpcsreset_req = 1'b1;
    step();
    k = $urandom_range(1, PULSE - 1);
    repeat (k - 1) step();
    chk("loss_in_pulse", txpcsreset, 1'b1);
    cplllock = 1'b0;
    step();
    m_loss++;
    chk("loss_sata_rst", {sata_rst, txpcsreset}, 2'b10);
    chk("loss_userrdy", {txuserrdy, rxuserrdy, recal_tx_done}, 3'b000);
    chk("loss_cfg", gtx_configured, 1'b1);
    txpcsreset_req = 1'b0;
    step();
    chk("loss_ready_low", {gtx_ready, gtx_configured}, 2'b01);
    chk("loss_rate_kept", txrate, m_rate);

    // Relock with rxresetdone low: WAIT times out and retries
    rxresetdone = 1'b0;
    repeat ($urandom_range(0, 5)) step();
    chk("loss_stays_lock", sata_rst, 1'b1);
    cplllock = 1'b1;
    step();
    run_len(0, 1'b1, n);
    chk("relock_hold_len", n, HOLD);
    run_len(0, 1'b0, n);
    m_retry++;
    chk("wait_to_len", n, TO);
    chk("wait_to_hold", {sata_rst, txuserrdy, rxuserrdy}, 3'b100);
    dbg_chk("dbg_after_wait_to");
    run_len(0, 1'b1, n);
    chk("retry_hold_len", n, HOLD);
    rxresetdone = 1'b1;
    step();
    chk("retry_ready", {gtx_ready, gtx_configured}, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
